multi_alarm_timekeeper: RTL and testbench
=========================================

Name: multi_alarm_timekeeper

Overview:
- Parametrised successor to the single-alarm clock core: BCD time-of-day counter (hh:mm:ss) with an internal 1 Hz prescaler, 12/24 h display mode and hour/minute adjust.
- Adds N independently programmable alarm channels, each with timed ringing, plus a global acknowledge.
- Sits between the board clock input and the 7-segment/LED display drivers.

Parameters:
- CLK_DIV, 50000000, clock cycles per second tick; benches use 4.
- N_ALARM, 4, number of alarm channels (1..8).
- RING_SEC, 30, seconds an alarm rings before self-clearing (1..255).

Ports:
- CP  input  1  system clock, rising edge.
- CR  input  1  synchronous reset, active-high.
- EN  input  1  run enable for the prescaler; counting freezes when low.
- Ctrl24To12  input  1  display mode: 0 = 24 h, 1 = 12 h.
- AdjH  input  1  one-cycle pulse; hour +1.
- AdjM  input  1  one-cycle pulse; minute +1.
- AlarmWr  input  1  one-cycle write strobe.
- AlarmSel  input  3  target channel index.
- AlarmHour  input  8  BCD hour, 24 h form.
- AlarmMin  input  8  BCD minute.
- AlarmOn  input  1  channel enable written with the time.
- AlarmAck  input  1  clears all ringing.
- Hour  output  8  BCD display hour (mode-converted).
- Min  output  8  BCD minute.
- Sec  output  8  BCD second.
- PM  output  1  PM flag; 0 in 24 h mode.
- SecTick  output  1  one-cycle pulse per second.
- AlarmRing  output  N_ALARM  per-channel ringing.
- LEDAlarm  output  1  OR of AlarmRing.
- WrErr  output  1  one-cycle pulse on a rejected write.
- Chime  output  1  hourly chime (see Optional Feature).

Behaviour:
- Reset (CR=1 at CP edge):
  - prescaler=0; time 00:00:00; all alarms 00:00 disabled.
  - All outputs 0, except Hour=0x00 in 24 h mode or 0x12 in 12 h mode (comb. from counters).
- Prescaler:
  - Counts 0..CLK_DIV-1 while EN=1; holds while EN=0.
  - Terminal count raises the internal tick and SecTick for that cycle.
  - Time registers update on the same edge.
- Time counting: Sec 00..59 wraps with carry to Min; Min 00..59 wraps with carry to Hour; internal Hour 00..23 wraps to 00. BCD digits must never leave 0-9.
- Adjust:
  - AdjM sets Min=(Min+1) mod 60, with no carry to Hour and Sec unaffected.
  - AdjH sets Hour=(Hour+1) mod 24.
  - Both work while EN=0.
  - On the same edge as a tick, adjust wins for its field: the tick's carry into that field is dropped, while Sec still advances.
  - AdjH and AdjM together apply both.
- Display mode (combinational, no latency):
  - 24 h: Hour = internal hour, PM=0.
  - 12 h: 00→12 AM, 01-11 AM, 12→12 PM, 13-23→01-11 PM.
- Alarm write:
  - Latches AlarmHour/AlarmMin/AlarmOn into channel AlarmSel on the next edge.
  - Rejected with a WrErr pulse the following cycle, and nothing stored, if AlarmSel≥N_ALARM, hour>0x23, min>0x59, or any nibble>9.
  - A write to a ringing channel clears its ring.
- Alarm match: evaluated only on a tick whose result is Sec=00, with the new Hour:Min equal to the channel value and On=1. Ring[i] is set on that edge. Adjust never triggers a match.
- Ring:
  - Per-channel counter loads RING_SEC on the match and decrements on each tick; the ring clears when it reaches 0.
  - AlarmAck clears all rings and counters on the next edge.
  - Ack has priority over a match on the same edge.
  - A re-match while ringing reloads the counter.
- Reset mid-ring clears everything immediately.

Optional Feature:
- Macro: HOURLY_CHIME_EN.
- Defined: Chime goes high on the tick that rolls Min 59→00 (not by AdjM) and stays high for exactly one second, i.e. until the next tick. It is suppressed while any AlarmRing bit is set.
- Undefined: Chime tied 0; port still present.

Decomposition:
- Shared package clock_pkg holds:
  - typedef bcd8_t (2 BCD digits);
  - constants SEC_MAX=8'h59, MIN_MAX=8'h59, HOUR_MAX=8'h23;
  - functions bcd_inc_wrap(value, max) and bcd_valid(value, max);
  - function to_12h(hour) returning {pm, hour12}.
- Sub-module alarm_channel, instantiated N_ALARM times: stores hour/min/on, match compare, ring counter.

Test Plan:
- Reset, then CLK_DIV=4 and run 240 cycles → SecTick every 4th cycle; Sec=0x59 after 59 ticks; Min=0x01, Sec=0x00 after 60 ticks.
- Preload 23:59:59 via AdjH/AdjM plus ticks, then one tick → 00:00:00. With Ctrl24To12=1, Hour=0x12, PM=0; at internal 13:xx, Hour=0x01, PM=1.
- AdjM at 00:59:xx coincident with the Sec 59→00 tick → Min=0x00, Hour unchanged 0x00, Sec=0x00.
- Write channel 2 = 00:01 On, run to 00:01:00 → AlarmRing=4'b0100 and LEDAlarm=1 on that tick; clears after 30 ticks (RING_SEC=30). A second run with AlarmAck at tick 5 clears it next cycle.
- Writes with AlarmSel=5 (N_ALARM=4), AlarmHour=0x24, and AlarmMin=0x5A → WrErr pulse each time; stored values unchanged on readback via match test.
- With HOURLY_CHIME_EN, run across 00:59:59→01:00:00 → Chime=1 for CLK_DIV cycles. AdjM 59→00 gives no chime. Without the macro, Chime stays 0.

Source files
------------

// File: rtl/multi_alarm_timekeeper_pkg.sv
// clock_pkg: shared types, limits and BCD helpers for the multi-alarm
// timekeeper and its alarm channels.
//   bcd8_t        two packed BCD digits {tens, ones}
//   SEC/MIN/HOUR_MAX  largest legal BCD value of each time field
//   bcd_inc_wrap  BCD increment that wraps to 00 past the field maximum
//   bcd_valid     both digits 0-9 and value not above the field maximum
//   to_12h        24 h BCD hour -> {pm, 12 h BCD hour}
package clock_pkg;

  typedef logic [7:0] bcd8_t;

  localparam bcd8_t SEC_MAX  = 8'h59;
  localparam bcd8_t MIN_MAX  = 8'h59;
  localparam bcd8_t HOUR_MAX = 8'h23;

  function automatic bcd8_t bcd_inc_wrap(input bcd8_t value, input bcd8_t max_val);
    bcd8_t r;
    if (value >= max_val) begin
      r = 8'h00;
    end else if (value[3:0] == 4'd9) begin
      r = {value[7:4] + 4'd1, 4'd0};
    end else begin
      r = value + 8'd1;
    end
    return r;
  endfunction

  function automatic logic bcd_valid(input bcd8_t value, input bcd8_t max_val);
    return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= max_val);
  endfunction

  // Converts through binary: hours fit in 7 bits, and the 12 h fold is a
  // plain subtract there instead of a BCD borrow.
  function automatic logic [8:0] to_12h(input bcd8_t hour);
    logic [6:0] b;
    logic [6:0] b12;
    logic [6:0] lo;
    logic       pm;
    bcd8_t      h12;
    // tens*10 = tens*8 + tens*2
    b   = {hour[7:4], 3'b000} + {2'b00, hour[7:4], 1'b0} + {3'b000, hour[3:0]};
    pm  = (b >= 7'd12);
    if (b == 7'd0) begin
      b12 = 7'd12;
    end else if (b > 7'd12) begin
      b12 = b - 7'd12;
    end else begin
      b12 = b;
    end
    if (b12 >= 7'd10) begin
      lo  = b12 - 7'd10;
      h12 = {4'h1, lo[3:0]};
    end else begin
      h12 = {4'h0, b12[3:0]};
    end
    return {pm, h12};
  endfunction

endpackage

// File: rtl/multi_alarm_timekeeper_alarm_channel.sv
// alarm_channel: one programmable alarm.
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_wr              accepted write to this channel (already validated)
//   i_wr_hour/min/on  values latched on i_wr
//   i_tick            one-second tick
//   i_match_stb       tick whose result is Sec=00 and not caused by adjust
//   i_hour_nx/min_nx  time that becomes current on this edge
//   i_ack             global acknowledge, clears the ring
//   o_ring            channel is ringing
module alarm_channel
  import clock_pkg::*;
#(
  parameter int RING_SEC = 30
) (
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_wr,
  input  bcd8_t i_wr_hour,
  input  bcd8_t i_wr_min,
  input  logic  i_wr_on,
  input  logic  i_tick,
  input  logic  i_match_stb,
  input  bcd8_t i_hour_nx,
  input  bcd8_t i_min_nx,
  input  logic  i_ack,
  output logic  o_ring
);

  bcd8_t      r_hour;
  bcd8_t      r_min;
  logic       r_on;
  logic       r_ring;
  logic [7:0] r_cnt;
  logic       w_match;

  // Compares against the stored value from before this edge, so a write
  // landing on a match edge does not see its own new value.
  assign w_match = i_match_stb && r_on && (r_hour == i_hour_nx) && (r_min == i_min_nx);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hour <= 8'h00;
      r_min  <= 8'h00;
      r_on   <= 1'b0;
    end else if (i_wr) begin
      r_hour <= i_wr_hour;
      r_min  <= i_wr_min;
      r_on   <= i_wr_on;
    end
  end

  // Priority: ack, then rewrite of the channel, then a (re)match reload,
  // then the per-second countdown.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ring <= 1'b0;
      r_cnt  <= 8'd0;
    end else if (i_ack || i_wr) begin
      r_ring <= 1'b0;
      r_cnt  <= 8'd0;
    end else if (w_match) begin
      r_ring <= 1'b1;
      r_cnt  <= 8'(RING_SEC);
    end else if (i_tick && r_ring) begin
      if (r_cnt <= 8'd1) begin
        r_ring <= 1'b0;
        r_cnt  <= 8'd0;
      end else begin
        r_cnt  <= r_cnt - 8'd1;
      end
    end
  end

  assign o_ring = r_ring;

endmodule

// File: rtl/multi_alarm_timekeeper.sv
// multi_alarm_timekeeper: BCD hh:mm:ss clock with 1 Hz prescaler, 12/24 h
// display, hour/minute adjust and N_ALARM programmable ringing alarms.
// Optional feature macro: HOURLY_CHIME_EN (hourly one-second chime; when
// undefined Chime is tied low).
// Ports:
//   CP, CR        clock (rising), synchronous active-high reset
//   EN            prescaler run enable
//   Ctrl24To12    display mode, 1 = 12 h
//   AdjH, AdjM    one-cycle hour / minute increment pulses
//   AlarmWr       alarm write strobe with AlarmSel/AlarmHour/AlarmMin/AlarmOn
//   AlarmAck      clears every ringing channel
//   Hour/Min/Sec  BCD display time, PM flag (12 h mode only)
//   SecTick       one-cycle pulse per second
//   AlarmRing     per-channel ring, LEDAlarm = OR of rings
//   WrErr         one-cycle pulse after a rejected write
//   Chime         hourly chime
module multi_alarm_timekeeper
  import clock_pkg::*;
#(
  parameter int CLK_DIV  = 50000000,
  parameter int N_ALARM  = 4,
  parameter int RING_SEC = 30
) (
  input  logic               CP,
  input  logic               CR,
  input  logic               EN,
  input  logic               Ctrl24To12,
  input  logic               AdjH,
  input  logic               AdjM,
  input  logic               AlarmWr,
  input  logic [2:0]         AlarmSel,
  input  logic [7:0]         AlarmHour,
  input  logic [7:0]         AlarmMin,
  input  logic               AlarmOn,
  input  logic               AlarmAck,
  output logic [7:0]         Hour,
  output logic [7:0]         Min,
  output logic [7:0]         Sec,
  output logic               PM,
  output logic               SecTick,
  output logic [N_ALARM-1:0] AlarmRing,
  output logic               LEDAlarm,
  output logic               WrErr,
  output logic               Chime
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] r_presc;
  bcd8_t         r_hour;
  bcd8_t         r_min;
  bcd8_t         r_sec;
  logic          r_wrerr;

  logic          w_tick;
  logic          w_sec_carry;
  logic          w_min_carry;
  logic          w_match_stb;
  logic          w_sel_ok;
  logic          w_wr_ok;
  bcd8_t         w_sec_nx;
  bcd8_t         w_min_nx;
  bcd8_t         w_hour_nx;
  logic [8:0]    w_disp;

  // Next-time computation. An adjust owns its field on a tick edge: the
  // carry that would have entered it is dropped, and an adjust wrap never
  // carries onward.
  always_comb begin
    w_tick      = EN && (r_presc == PW'(CLK_DIV - 1));
    w_sec_carry = w_tick && (r_sec == SEC_MAX);
    w_min_carry = w_sec_carry && (r_min == MIN_MAX) && !AdjM;
    w_sec_nx    = w_tick ? bcd_inc_wrap(r_sec, SEC_MAX) : r_sec;
    w_min_nx    = (AdjM || w_sec_carry) ? bcd_inc_wrap(r_min, MIN_MAX) : r_min;
    w_hour_nx   = (AdjH || w_min_carry) ? bcd_inc_wrap(r_hour, HOUR_MAX) : r_hour;
    // Only a real second rollover may fire an alarm; any adjust on the
    // same edge suppresses matching.
    w_match_stb = w_tick && (w_sec_nx == 8'h00) && !AdjH && !AdjM;
    w_sel_ok    = ({1'b0, AlarmSel} < 4'(N_ALARM));
    w_wr_ok     = AlarmWr && w_sel_ok && bcd_valid(AlarmHour, HOUR_MAX)
                  && bcd_valid(AlarmMin, MIN_MAX);
  end

  always_ff @(posedge CP) begin
    if (CR) begin
      r_presc <= '0;
    end else if (EN) begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
    end
  end

  always_ff @(posedge CP) begin
    if (CR) begin
      r_sec   <= 8'h00;
      r_min   <= 8'h00;
      r_hour  <= 8'h00;
      r_wrerr <= 1'b0;
    end else begin
      r_sec   <= w_sec_nx;
      r_min   <= w_min_nx;
      r_hour  <= w_hour_nx;
      r_wrerr <= AlarmWr && !w_wr_ok;
    end
  end

  for (genvar gi = 0; gi < N_ALARM; gi++) begin : g_alarm
    alarm_channel #(
      .RING_SEC (RING_SEC)
    ) u_ch (
      .i_clk       (CP),
      .i_rst       (CR),
      .i_wr        (w_wr_ok && (AlarmSel == 3'(gi))),
      .i_wr_hour   (AlarmHour),
      .i_wr_min    (AlarmMin),
      .i_wr_on     (AlarmOn),
      .i_tick      (w_tick),
      .i_match_stb (w_match_stb),
      .i_hour_nx   (w_hour_nx),
      .i_min_nx    (w_min_nx),
      .i_ack       (AlarmAck),
      .o_ring      (AlarmRing[gi])
    );
  end

`ifdef HOURLY_CHIME_EN
  logic r_chime;

  // Set by the tick that rolls minutes over the hour, held until the next tick.
  always_ff @(posedge CP) begin
    if (CR) begin
      r_chime <= 1'b0;
    end else if (w_min_carry) begin
      r_chime <= 1'b1;
    end else if (w_tick) begin
      r_chime <= 1'b0;
    end
  end

  assign Chime = r_chime && !LEDAlarm;
`else
  assign Chime = 1'b0;
`endif

  assign w_disp   = to_12h(r_hour);
  assign Hour     = Ctrl24To12 ? w_disp[7:0] : r_hour;
  assign PM       = Ctrl24To12 && w_disp[8];
  assign Min      = r_min;
  assign Sec      = r_sec;
  assign SecTick  = w_tick;
  assign LEDAlarm = |AlarmRing;
  assign WrErr    = r_wrerr;

endmodule

// File: tb/tb_multi_alarm_timekeeper.sv
module tb_multi_alarm_timekeeper;

  localparam int CLK_DIV  = 4;
  localparam int N_ALARM  = 4;
  localparam int RING_SEC = 30;

  logic       clk = 1'b0;
  logic       CR = 1'b1, EN = 1'b0, Ctrl24To12 = 1'b0, AdjH = 1'b0, AdjM = 1'b0;
  logic       AlarmWr = 1'b0, AlarmOn = 1'b0, AlarmAck = 1'b0;
  logic [2:0] AlarmSel = 3'd0;
  logic [7:0] AlarmHour = 8'h00, AlarmMin = 8'h00;
  logic [7:0] Hour, Min, Sec;
  logic       PM, SecTick, LEDAlarm, WrErr, Chime;
  logic [N_ALARM-1:0] AlarmRing;

  multi_alarm_timekeeper #(.CLK_DIV(CLK_DIV), .N_ALARM(N_ALARM), .RING_SEC(RING_SEC)) dut (
    .CP(clk), .CR(CR), .EN(EN), .Ctrl24To12(Ctrl24To12), .AdjH(AdjH), .AdjM(AdjM),
    .AlarmWr(AlarmWr), .AlarmSel(AlarmSel), .AlarmHour(AlarmHour), .AlarmMin(AlarmMin),
    .AlarmOn(AlarmOn), .AlarmAck(AlarmAck), .Hour(Hour), .Min(Min), .Sec(Sec), .PM(PM),
    .SecTick(SecTick), .AlarmRing(AlarmRing), .LEDAlarm(LEDAlarm), .WrErr(WrErr), .Chime(Chime)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] hour, min, sec;
    logic       pm, tick;
    logic [3:0] ring;
    logic       led, wrerr, chime;
  } exp_t;

  exp_t sb[$];

  // Reference model kept in plain decimal integers.
  int m_presc, m_h, m_m, m_s;
  int m_ah[N_ALARM], m_am[N_ALARM], m_cnt[N_ALARM];
  bit m_on[N_ALARM], m_ring[N_ALARM];
  bit m_wrerr, m_chime;

  function automatic int bcd2int(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic model_step();
    bit tick, cs, cm, match, ok, hit;
    int s_n, mi_n, h_n;
    if (CR) begin
      m_presc = 0; m_h = 0; m_m = 0; m_s = 0; m_wrerr = 0; m_chime = 0;
      for (int i = 0; i < N_ALARM; i++) begin
        m_ah[i] = 0; m_am[i] = 0; m_cnt[i] = 0; m_on[i] = 0; m_ring[i] = 0;
      end
    end else begin
      tick = EN && (m_presc == CLK_DIV - 1);
      cs   = tick && (m_s == 59);
      s_n  = tick ? (m_s + 1) % 60 : m_s;
      mi_n = (AdjM || cs) ? (m_m + 1) % 60 : m_m;
      cm   = cs && (m_m == 59) && !AdjM;
      h_n  = (AdjH || cm) ? (m_h + 1) % 24 : m_h;
      match = tick && (s_n == 0) && !AdjH && !AdjM;
      ok = (int'(AlarmSel) < N_ALARM) && (AlarmHour[7:4] <= 9) && (AlarmHour[3:0] <= 9)
           && (AlarmMin[7:4] <= 9) && (AlarmMin[3:0] <= 9)
           && (bcd2int(AlarmHour) <= 23) && (bcd2int(AlarmMin) <= 59);
      for (int i = 0; i < N_ALARM; i++) begin
        hit = AlarmWr && ok && (int'(AlarmSel) == i);
        if (AlarmAck || hit) begin
          m_ring[i] = 0; m_cnt[i] = 0;
        end else if (match && m_on[i] && (h_n == m_ah[i]) && (mi_n == m_am[i])) begin
          m_ring[i] = 1; m_cnt[i] = RING_SEC;
        end else if (tick && m_ring[i]) begin
          m_cnt[i] = m_cnt[i] - 1;
          if (m_cnt[i] == 0) m_ring[i] = 0;
        end
        if (hit) begin
          m_ah[i] = bcd2int(AlarmHour); m_am[i] = bcd2int(AlarmMin); m_on[i] = AlarmOn;
        end
      end
      if (cm) m_chime = 1;
      else if (tick) m_chime = 0;
      m_wrerr = AlarmWr && !ok;
      m_presc = EN ? (tick ? 0 : m_presc + 1) : m_presc;
      m_s = s_n; m_m = mi_n; m_h = h_n;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int   h12;
    bit   any;
    any = 0;
    for (int i = 0; i < N_ALARM; i++) begin
      e.ring[i] = m_ring[i];
      any |= m_ring[i];
    end
    if (Ctrl24To12) begin
      h12 = (m_h == 0) ? 12 : (m_h > 12) ? m_h - 12 : m_h;
      e.hour = int2bcd(h12);
      e.pm   = (m_h >= 12);
    end else begin
      e.hour = int2bcd(m_h);
      e.pm   = 1'b0;
    end
    e.min   = int2bcd(m_m);
    e.sec   = int2bcd(m_s);
    e.tick  = EN && (m_presc == CLK_DIV - 1);
    e.led   = any;
    e.wrerr = m_wrerr;
`ifdef HOURLY_CHIME_EN
    e.chime = m_chime && !any;
`else
    e.chime = 1'b0;
`endif
    return e;
  endfunction

  // One clock: model predicts, prediction is queued, DUT is sampled 1 time
  // unit after the edge and the prediction popped against it.
  task automatic step();
    exp_t e;
    model_step();
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    cyc++;
    e = sb.pop_front();
    n_vec++;
    if (Hour !== e.hour || Min !== e.min || Sec !== e.sec || PM !== e.pm ||
        SecTick !== e.tick || AlarmRing !== e.ring || LEDAlarm !== e.led ||
        WrErr !== e.wrerr || Chime !== e.chime) begin
      n_bad++;
      $display("FAIL model cyc%0d got %h:%h:%h pm=%b tk=%b ring=%b led=%b err=%b ch=%b want %h:%h:%h pm=%b tk=%b ring=%b led=%b err=%b ch=%b",
               cyc, Hour, Min, Sec, PM, SecTick, AlarmRing, LEDAlarm, WrErr, Chime,
               e.hour, e.min, e.sec, e.pm, e.tick, e.ring, e.led, e.wrerr, e.chime);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    CR = 1'b1; EN = 1'b0; AdjH = 1'b0; AdjM = 1'b0; AlarmWr = 1'b0; AlarmAck = 1'b0;
    step();
    CR = 1'b0;
  endtask

  task automatic pulse_h(input int n);
    for (int i = 0; i < n; i++) begin AdjH = 1'b1; step(); AdjH = 1'b0; end
  endtask

  task automatic pulse_m(input int n);
    for (int i = 0; i < n; i++) begin AdjM = 1'b1; step(); AdjM = 1'b0; end
  endtask

  task automatic wr(input logic [2:0] sel, input logic [7:0] h, input logic [7:0] m, input logic on);
    AlarmSel = sel; AlarmHour = h; AlarmMin = m; AlarmOn = on; AlarmWr = 1'b1;
    step();
    AlarmWr = 1'b0;
  endtask

  typedef struct { int adj; logic c12; logic [7:0] hour; logic pm; } disp_vec_t;
  typedef struct { logic [2:0] sel; logic [7:0] hour, min; logic on; logic err; } wr_vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    disp_vec_t dv[8];
    wr_vec_t   wv[6];
    int        cnt;

    dv[0] = '{0,  1'b1, 8'h12, 1'b0};
    dv[1] = '{1,  1'b1, 8'h01, 1'b0};
    dv[2] = '{11, 1'b1, 8'h11, 1'b0};
    dv[3] = '{12, 1'b1, 8'h12, 1'b1};
    dv[4] = '{13, 1'b1, 8'h01, 1'b1};
    dv[5] = '{23, 1'b1, 8'h11, 1'b1};
    dv[6] = '{13, 1'b0, 8'h13, 1'b0};
    dv[7] = '{23, 1'b0, 8'h23, 1'b0};

    wv[0] = '{3'd1, 8'h00, 8'h01, 1'b1, 1'b0};
    wv[1] = '{3'd5, 8'h00, 8'h01, 1'b0, 1'b1};
    wv[2] = '{3'd1, 8'h24, 8'h01, 1'b0, 1'b1};
    wv[3] = '{3'd1, 8'h00, 8'h5A, 1'b0, 1'b1};
    wv[4] = '{3'd1, 8'h0A, 8'h01, 1'b0, 1'b1};
    wv[5] = '{3'd7, 8'h00, 8'h01, 1'b0, 1'b1};

    // Reset values in both display modes.
    do_reset();
    check("rst_hour24", Hour, 8'h00);
    check("rst_min", Min, 8'h00);
    check("rst_sec", Sec, 8'h00);
    check("rst_ring", AlarmRing, 4'b0000);
    Ctrl24To12 = 1'b1; #1;
    check("rst_hour12", Hour, 8'h12);
    check("rst_pm12", PM, 1'b0);
    Ctrl24To12 = 1'b0;

    // Free run: one tick per CLK_DIV cycles.
    EN = 1'b1; cnt = 0;
    for (int c = 1; c <= 240; c++) begin
      step();
      cnt += int'(SecTick);
      if (c == 236) check("sec59", Sec, 8'h59);
    end
    check("tick_count", cnt, 60);
    check("min01", Min, 8'h01);
    check("sec00", Sec, 8'h00);

    // Display conversion table.
    foreach (dv[i]) begin
      do_reset();
      pulse_h(dv[i].adj);
      Ctrl24To12 = dv[i].c12;
      step();
      check($sformatf("disp%0d_hour", i), Hour, dv[i].hour);
      check($sformatf("disp%0d_pm", i), PM, dv[i].pm);
      Ctrl24To12 = 1'b0;
    end

    // Midnight rollover from 23:59:59.
    do_reset();
    pulse_h(23); pulse_m(59);
    EN = 1'b1;
    run(236);
    check("pre_hour", Hour, 8'h23);
    check("pre_min", Min, 8'h59);
    check("pre_sec", Sec, 8'h59);
    run(4);
    check("mid_hour", Hour, 8'h00);
    check("mid_min", Min, 8'h00);
    check("mid_sec", Sec, 8'h00);
    Ctrl24To12 = 1'b1; #1;
    check("mid_hour12", Hour, 8'h12);
    check("mid_pm", PM, 1'b0);
    Ctrl24To12 = 1'b0;

    // AdjM coincident with the tick that would carry into minutes.
    do_reset();
    pulse_m(59);
    EN = 1'b1;
    run(236);
    run(3);
    AdjM = 1'b1; step(); AdjM = 1'b0;
    check("adjm_tick_min", Min, 8'h00);
    check("adjm_tick_hour", Hour, 8'h00);
    check("adjm_tick_sec", Sec, 8'h00);

    // Channel 2 alarm at 00:01, rings for RING_SEC ticks.
    do_reset();
    wr(3'd2, 8'h00, 8'h01, 1'b1);
    EN = 1'b1;
    run(240);
    check("ring_set", AlarmRing, 4'b0100);
    check("led_set", LEDAlarm, 1'b1);
    run(116);
    check("ring_hold", AlarmRing, 4'b0100);
    run(4);
    check("ring_clear", AlarmRing, 4'b0000);
    check("led_clear", LEDAlarm, 1'b0);

    // Same alarm acknowledged at the fifth ringing tick.
    do_reset();
    wr(3'd2, 8'h00, 8'h01, 1'b1);
    EN = 1'b1;
    run(260);
    check("ack_pre", AlarmRing, 4'b0100);
    AlarmAck = 1'b1; step(); AlarmAck = 1'b0;
    check("ack_ring", AlarmRing, 4'b0000);

    // Rejected writes leave channel 1 untouched.
    do_reset();
    foreach (wv[i]) begin
      wr(wv[i].sel, wv[i].hour, wv[i].min, wv[i].on);
      check($sformatf("wrerr%0d", i), WrErr, wv[i].err);
      step();
      check($sformatf("wrerr%0d_end", i), WrErr, 1'b0);
    end
    EN = 1'b1;
    run(240);
    check("wr_keep_ring", AlarmRing, 4'b0010);

    // Hourly chime across 00:59:59 -> 01:00:00.
    do_reset();
    pulse_m(59);
    EN = 1'b1;
    run(239);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin step(); cnt += int'(Chime); end
    check("chime_hour", Hour, 8'h01);
`ifdef HOURLY_CHIME_EN
    check("chime_len", cnt, CLK_DIV);
`else
    check("chime_len", cnt, 0);
`endif

    // A minute wrap by AdjM never chimes.
    do_reset();
    pulse_m(59);
    cnt = 0;
    AdjM = 1'b1; step(); AdjM = 1'b0;
    cnt += int'(Chime);
    for (int i = 0; i < 7; i++) begin step(); cnt += int'(Chime); end
    check("adjm_nochime", cnt, 0);
    check("adjm_wrap_hour", Hour, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
